tdm_demux_4: RTL

// - Receive-side partner of the 4:1 selector used as a TDM serialiser: one serial bit per

---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_demux_4_if.sv | 24 ++
 rtl/tdm_lane_reg.sv | 23 ++
 rtl/tdm_demux_4.sv | 112 +++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM constants and FSM state encoding for the transmit and receive sides.
package tdm_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned W      = 4;
    localparam int unsigned SEL_W  = $clog2(LANES);
    localparam int unsigned CNT_W  = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned WORD_W = LANES * W;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux_4_if.sv
// Serial-link side and lane-consumer side of the TDM de-interleaver.
interface tdm_demux_4_if;
    import tdm_pkg::*;

    logic              en;
    logic              in;
    logic              sync;
    logic [WORD_W-1:0] out;
    logic              valid;
    logic [SEL_W-1:0]  sel;
    logic              locked;
    logic              sync_err;

    modport master (
        output en, in, sync,
        input  out, valid, sel, locked, sync_err
    );

    modport slave (
        input  en, in, sync,
        output out, valid, sel, locked, sync_err
    );

endinterface

// File: rtl/tdm_lane_reg.sv
// One lane word: W-bit register written one bit at a time.
module tdm_lane_reg #(
    parameter int unsigned W     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [IDX_W-1:0] idx,
    input  logic             d,
    output logic [W-1:0]     q
);

    // Single-bit write at idx; other bits hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (wr) begin
            q[idx] <= d;
        end
    end

endmodule

// File: rtl/tdm_demux_4.sv
// TDM receive de-interleaver: serial bits, round-robin over LANES slots, into lane words.
module tdm_demux_4
    import tdm_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    tdm_demux_4_if.slave   bus
);

    state_t              state;
    logic [SEL_W-1:0]    slot;
    logic [CNT_W-1:0]    bitcnt;
    logic [WORD_W-1:0]   out_q;
    logic                valid_q;
    logic                err_q;
    logic                locked_q;

    logic [LANES-1:0]    wr_c;
    logic [CNT_W-1:0]    idx_c;
    logic                restart_c;
    logic                misalign_c;
    logic                complete_c;
    logic [WORD_W-1:0]   lanes_q;
    logic [WORD_W-1:0]   word_c;

    // Decode where the current bit lands; a restart forces it to lane0 bit0.
    always_comb begin
        wr_c       = '0;
        idx_c      = '0;
        restart_c  = 1'b0;
        misalign_c = 1'b0;
        complete_c = 1'b0;
        if (bus.en) begin
            if (state == ST_HUNT) begin
                restart_c = bus.sync;
            end else if (bus.sync && (slot != '0)) begin
                restart_c  = 1'b1;
                misalign_c = 1'b1;
            end else begin
                wr_c[slot] = 1'b1;
                idx_c      = bitcnt;
                complete_c = (slot == SEL_W'(LANES - 1)) && (bitcnt == CNT_W'(W - 1));
            end
        end
        if (restart_c) begin
            wr_c    = '0;
            wr_c[0] = 1'b1;
            idx_c   = '0;
        end
    end

    // Finished word includes the bit arriving this cycle (last lane, top bit).
    always_comb begin
        word_c             = lanes_q;
        word_c[WORD_W-1]   = bus.in;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        tdm_lane_reg #(
            .W     (W),
            .IDX_W (CNT_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr_c[k]),
            .idx   (idx_c),
            .d     (bus.in),
            .q     (lanes_q[k*W +: W])
        );
    end

    // FSM, slot/bit counters, output word and one-cycle pulse flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_HUNT;
            slot     <= '0;
            bitcnt   <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (restart_c) begin
                state    <= ST_RUN;
                locked_q <= 1'b1;
                slot     <= SEL_W'(1);
                bitcnt   <= '0;
                err_q    <= misalign_c;
            end else if (bus.en && (state == ST_RUN)) begin
                slot <= slot + SEL_W'(1);
                if (slot == SEL_W'(LANES - 1)) begin
                    if (complete_c) begin
                        bitcnt  <= '0;
                        out_q   <= word_c;
                        valid_q <= 1'b1;
                    end else begin
                        bitcnt <= bitcnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.out      = out_q;
    assign bus.valid    = valid_q;
    assign bus.sel      = slot;
    assign bus.locked   = locked_q;
    assign bus.sync_err = err_q;

endmodule
